// File: rtl/riscv_apu_wb_buffer.sv
module riscv_apu_wb_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FLAGS_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       apu_result_valid_i,
  input  logic [DATA_WIDTH-1:0]      apu_result_i,
  input  logic [FLAGS_WIDTH-1:0]     apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
  output logic                       apu_result_ready_o,

  input  logic                       lsu_wb_req_i,

  output logic                       regfile_we_o,
  output logic [ADDR_WIDTH-1:0]      regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]      regfile_wdata_o,
  output logic                       fflags_we_o,
  output logic [FLAGS_WIDTH-1:0]     fflags_o,

  input  logic [3*ADDR_WIDTH-1:0]    read_regs_i,
  input  logic [2:0]                 read_regs_valid_i,
  output logic                       read_dep_o,

  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
  logic [FLAGS_WIDTH-1:0] flags_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];
  logic [DEPTH-1:0]       valid_q;

  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;

  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   bypass;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count_o = count_q;
  assign empty_o = empty;

  assign apu_result_ready_o = !full && !rst_i;
  assign accept = apu_result_valid_i && apu_result_ready_o;

  assign bypass = accept && empty && !lsu_wb_req_i;
  assign pop    = !rst_i && !empty && !lsu_wb_req_i;
  assign push   = accept && !bypass;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q]  <= apu_result_i;
      flags_q[wr_ptr_q] <= apu_flags_i;
      addr_q[wr_ptr_q]  <= apu_waddr_i;
    end
  end

  always_comb begin
    regfile_we_o    = 1'b0;
    regfile_waddr_o = '0;
    regfile_wdata_o = '0;
    fflags_we_o     = 1'b0;
    fflags_o        = '0;
    if (!rst_i && !lsu_wb_req_i) begin
      if (!empty) begin
        regfile_we_o    = 1'b1;
        regfile_waddr_o = addr_q[rd_ptr_q];
        regfile_wdata_o = data_q[rd_ptr_q];
        fflags_we_o     = 1'b1;
        fflags_o        = flags_q[rd_ptr_q];
      end else if (accept) begin
        regfile_we_o    = 1'b1;
        regfile_waddr_o = apu_waddr_i;
        regfile_wdata_o = apu_result_i;
        fflags_we_o     = 1'b1;
        fflags_o        = apu_flags_i;
      end
    end
  end

  always_comb begin
    read_dep_o = 1'b0;
    if (!rst_i) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (valid_q[e] && read_regs_valid_i[i] &&
              (addr_q[e] == read_regs_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            read_dep_o = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    assert (!(regfile_we_o && lsu_wb_req_i))
      else $error("regfile_we_o asserted while lsu_wb_req_i is high");
  end

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// Self-checking bench for riscv_apu_wb_buffer: directed scenarios followed by
// constrained-random traffic, all checked against a queue-based reference model.
module tb_riscv_apu_wb_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned FW    = 5;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            apu_valid;
    logic [DW-1:0]   apu_data;
    logic [FW-1:0]   apu_flags;
    logic [AW-1:0]   apu_waddr;
    logic            apu_ready;
    logic            lsu_req;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            ff_we;
    logic [FW-1:0]   ff_val;
    logic [3*AW-1:0] rregs;
    logic [2:0]      rregs_v;
    logic            rdep;
    logic [CW-1:0]   count;
    logic            empty;

    riscv_apu_wb_buffer #(
        .DATA_WIDTH (DW),
        .FLAGS_WIDTH(FW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .apu_result_valid_i(apu_valid),
        .apu_result_i      (apu_data),
        .apu_flags_i       (apu_flags),
        .apu_waddr_i       (apu_waddr),
        .apu_result_ready_o(apu_ready),
        .lsu_wb_req_i      (lsu_req),
        .regfile_we_o      (rf_we),
        .regfile_waddr_o   (rf_waddr),
        .regfile_wdata_o   (rf_wdata),
        .fflags_we_o       (ff_we),
        .fflags_o          (ff_val),
        .read_regs_i       (rregs),
        .read_regs_valid_i (rregs_v),
        .read_dep_o        (rdep),
        .count_o           (count),
        .empty_o           (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [FW-1:0] f;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   writes = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs at negedge, advance model at posedge.
    task automatic cyc(input logic r, input logic v, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [FW-1:0] f,
                       input logic [3*AW-1:0] rr, input logic [2:0] rv, output logic acc);
        logic          exp_ready, exp_we, exp_dep, bypassed;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [FW-1:0] ef;
        logic [AW-1:0] src;
        ent_t          e;
        rst = r; apu_valid = v; lsu_req = l; apu_waddr = a; apu_data = d; apu_flags = f;
        rregs = rr; rregs_v = rv;
        @(negedge clk);
        exp_ready = !r && (q.size() < DEPTH);
        acc       = v && exp_ready;
        exp_we = 1'b0; ea = '0; ed = '0; ef = '0;
        if (!r && !l) begin
            if (q.size() > 0) begin
                exp_we = 1'b1; ea = q[0].a; ed = q[0].d; ef = q[0].f;
            end else if (acc) begin
                exp_we = 1'b1; ea = a; ed = d; ef = f;
            end
        end
        exp_dep = 1'b0;
        if (!r) begin
            foreach (q[k]) begin
                for (int i = 0; i < 3; i++) begin
                    src = rr[i*AW +: AW];
                    if (rv[i] && src == q[k].a) exp_dep = 1'b1;
                end
            end
        end
        check("ready",    64'(apu_ready), 64'(exp_ready));
        check("we",       64'(rf_we),     64'(exp_we));
        check("waddr",    64'(rf_waddr),  64'(ea));
        check("wdata",    64'(rf_wdata),  64'(ed));
        check("fflags_we",64'(ff_we),     64'(exp_we));
        check("fflags",   64'(ff_val),    64'(ef));
        check("read_dep", 64'(rdep),      64'(exp_dep));
        check("count",    64'(count),     64'(q.size()));
        check("empty",    64'(empty),     64'(q.size() == 0));
        if (exp_we) writes++;
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            bypassed = (q.size() == 0) && !l && acc;
            if (!l && q.size() > 0) void'(q.pop_front());
            if (acc && !bypassed) begin
                e.a = a; e.d = d; e.f = f;
                q.push_back(e);
            end
        end
        #1;
    endtask

    logic          acc;
    logic          pend_v;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic [FW-1:0] pend_f;
    logic          r_r, r_l;

    initial begin
        rst = 1'b1; apu_valid = 1'b0; lsu_req = 1'b0; apu_waddr = '0; apu_data = '0;
        apu_flags = '0; rregs = '0; rregs_v = '0;
        @(posedge clk); #1;
        q.delete();

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, acc);
        cyc(1, 1, 0, 6'd1, 32'h1, 5'h1, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Bypass into empty buffer.
        cyc(0, 1, 0, 6'd5, 32'hDEADBEEF, 5'h1, {6'd0, 6'd0, 6'd5}, 3'b001, acc);
        check("bypass_count", 64'(count), 64'd0);

        // Blocked then drain, with dependency on r3.
        cyc(0, 1, 1, 6'd3, 32'hAAAA0003, 5'h2, 0, 0, acc);
        cyc(0, 1, 1, 6'd7, 32'hBBBB0007, 5'h4, {6'd0, 6'd0, 6'd3}, 3'b001, acc);
        cyc(0, 0, 1, 0, 0, 0, {6'd0, 6'd0, 6'd3}, 3'b001, acc);
        check("blocked_full_ready", 64'(apu_ready), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, {6'd0, 6'd0, 6'd3}, 3'b001, acc);
        cyc(0, 0, 0, 0, 0, 0, {6'd7, 6'd0, 6'd0}, 3'b100, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Ordering: queued r4 goes before new r9.
        cyc(0, 1, 1, 6'd4, 32'h44444444, 5'h3, 0, 0, acc);
        cyc(0, 1, 0, 6'd9, 32'h99999999, 5'h5, {6'd9, 6'd4, 6'd0}, 3'b110, acc);
        cyc(0, 0, 0, 0, 0, 0, {6'd0, 6'd0, 6'd9}, 3'b001, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Full backpressure with a held input.
        cyc(0, 1, 1, 6'd10, 32'h0A, 5'h6, 0, 0, acc);
        cyc(0, 1, 1, 6'd12, 32'h0C, 5'h7, 0, 0, acc);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 6'd11, 32'h0B, 5'h8, 0, 0, acc);
        cyc(0, 1, 0, 6'd11, 32'h0B, 5'h8, 0, 0, acc);
        check("full_no_accept", 64'(acc), 64'd0);
        cyc(0, 1, 0, 6'd11, 32'h0B, 5'h8, 0, 0, acc);
        check("release_accept", 64'(acc), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Reset mid-operation discards queued entries.
        cyc(0, 1, 1, 6'd20, 32'h20, 5'h9, 0, 0, acc);
        cyc(0, 1, 1, 6'd21, 32'h21, 5'hA, 0, 0, acc);
        cyc(1, 0, 0, 0, 0, 0, {6'd20, 6'd21, 6'd0}, 3'b110, acc);
        cyc(0, 0, 0, 0, 0, 0, {6'd20, 6'd21, 6'd0}, 3'b110, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Simultaneous push and pop at count=1 across pointer wrap.
        cyc(0, 1, 1, 6'd30, 32'h30, 5'h1, 0, 0, acc);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 6'(31 + i), 32'(32'h31 + i), 5'(i), 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, acc);

        // Random traffic with upstream holding results until accepted.
        pend_v = 1'b0; pend_a = '0; pend_d = '0; pend_f = '0;
        for (int n = 0; n < 600; n++) begin
            if (!pend_v && ($urandom_range(0, 1) == 1)) begin
                pend_v = 1'b1;
                pend_a = 6'($urandom_range(0, 7));
                pend_d = $urandom;
                pend_f = 5'($urandom);
            end
            r_l = ($urandom_range(0, 9) < 4);
            r_r = ($urandom_range(0, 49) == 0);
            cyc(r_r, pend_v, r_l, pend_a, pend_d, pend_f,
                18'({$urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)}),
                3'($urandom), acc);
            if (acc) pend_v = 1'b0;
        end
        check("writes_seen", 64'(writes > 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
